// File: rtl/ttpu_pkg.sv
// ============================================================================
// Module      : ttpu_pkg
// Description : Shared types and defaults for the ttpu datapath controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttpu_pkg;

    localparam int C_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } relu_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/relu_sequencer.sv
// ============================================================================
// Module      : relu_sequencer
// Description : Steps accumulator rows through the ReLU stage into the unified
//               buffer: read, capture, write (with backpressure), per row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module relu_sequencer
    import ttpu_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int CNT_WIDTH  = C_ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [CNT_WIDTH-1:0]  row_count,
    input  logic                  abort,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    output logic                  relu_en,
    output logic                  ub_wr_en,
    output logic [ADDR_WIDTH-1:0] ub_wr_addr,
    input  logic                  ub_wr_ready,
    output logic                  busy,
    output logic                  done
);

    relu_seq_state_t       r_state;
    relu_seq_state_t       w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] w_src_nxt;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] w_dst_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_last_row;

    assign w_last_row = (r_cnt == CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;

        // abort overrides every transition out of a busy state
        if ((r_state != IDLE) && abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        if (row_count == '0) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = RD;
                            w_src_nxt   = src_addr;
                            w_dst_nxt   = dst_addr;
                            w_cnt_nxt   = row_count;
                        end
                    end
                end
                RD:   w_state_nxt = CAP;
                CAP:  w_state_nxt = WR;
                WR: begin
                    if (ub_wr_ready) begin
                        w_cnt_nxt   = r_cnt - CNT_WIDTH'(1);
                        w_src_nxt   = r_src + ADDR_WIDTH'(1);
                        w_dst_nxt   = r_dst + ADDR_WIDTH'(1);
                        w_state_nxt = w_last_row ? DONE : RD;
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign acc_rd_en   = (r_state == RD);
    assign acc_rd_addr = r_src;
    assign relu_en     = (r_state == CAP);
    assign ub_wr_en    = (r_state == WR);
    assign ub_wr_addr  = r_dst;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_relu_sequencer.sv
// ============================================================================
// Module      : tb_relu_sequencer
// Description : Directed + randomized bench for relu_sequencer with a
//               cycle-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_relu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ub_wr_ready = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [8:0] row_count = '0;
    logic       acc_rd_en;
    logic [7:0] acc_rd_addr;
    logic       relu_en;
    logic       ub_wr_en;
    logic [7:0] ub_wr_addr;
    logic       busy;
    logic       done;

    relu_sequencer #(.ADDR_WIDTH(8), .CNT_WIDTH(9)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .row_count(row_count), .abort(abort),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .relu_en(relu_en),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_ready(ub_wr_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    bit pat [0:4095];

    // observed events, encoded as cycle*256 + address
    int a_rd[$], a_relu[$], a_wr[$], a_wra[$], a_done[$];
    int e_rd[$], e_relu[$], e_wr[$], e_wra[$], e_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        int rel;
        rel = cyc - t0;
        if (reset) begin
            total++;
            assert (!(relu_en && (acc_rd_en || ub_wr_en))) else begin
                bad++;
                $error("FAIL relu_excl cyc %0d: relu=%0b rd=%0b wr=%0b expected relu alone",
                       rel, relu_en, acc_rd_en, ub_wr_en);
            end
            if (acc_rd_en)               a_rd.push_back(rel * 256 + int'(acc_rd_addr));
            if (relu_en)                 a_relu.push_back(rel * 256);
            if (ub_wr_en)                a_wra.push_back(rel * 256 + int'(ub_wr_addr));
            if (ub_wr_en && ub_wr_ready) a_wr.push_back(rel * 256 + int'(ub_wr_addr));
            if (done)                    a_done.push_back(rel * 256);
        end
    end

    function automatic bit keep(input int c, input int ab);
        return (ab < 0) || (c <= ab);
    endfunction

    // Timeline model: row i read at t, captured at t+1, written from t+2 until ready.
    task automatic model(input int s, input int d, input int n, input int ab);
        int t, w;
        e_rd.delete(); e_relu.delete(); e_wr.delete(); e_wra.delete(); e_done.delete();
        t = 1;
        for (int i = 0; i < n; i++) begin
            if (keep(t, ab))     e_rd.push_back(t * 256 + (s + i) % 256);
            if (keep(t + 1, ab)) e_relu.push_back((t + 1) * 256);
            w = t + 2;
            while (!pat[w] && w < 4000) begin
                if (keep(w, ab)) e_wra.push_back(w * 256 + (d + i) % 256);
                w++;
            end
            if (keep(w, ab)) begin
                e_wra.push_back(w * 256 + (d + i) % 256);
                e_wr.push_back(w * 256 + (d + i) % 256);
            end
            t = w + 1;
        end
        if (keep(t, ab)) e_done.push_back(t * 256);
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int e[$], input int a[$]);
        chk_int({tag, "_count"}, a.size(), e.size());
        for (int i = 0; i < e.size() && i < a.size(); i++) begin
            total++;
            assert (a[i] === e[i]) else begin
                bad++;
                $error("FAIL %s[%0d]: got cyc %0d addr %02h expected cyc %0d addr %02h",
                       tag, i, a[i] / 256, a[i] % 256, e[i] / 256, e[i] % 256);
            end
        end
    endtask

    task automatic fill_pat(input bit rnd);
        for (int i = 0; i < 4096; i++) pat[i] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic run_cmd(input string tag, input int s, input int d, input int n,
                           input int ab, input int noise_at);
        int  rel;
        bit  finished;
        @(posedge clk); #1;
        a_rd.delete(); a_relu.delete(); a_wr.delete(); a_wra.delete(); a_done.delete();
        src_addr = 8'(s); dst_addr = 8'(d); row_count = 9'(n);
        start = 1'b1; abort = 1'b0; ub_wr_ready = pat[0];
        t0 = cyc;
        model(s, d, n, ab);
        finished = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            @(posedge clk); #1;
            rel = cyc - t0;
            start = 1'b0;
            abort = (rel == ab);
            ub_wr_ready = pat[rel % 4096];
            if (rel == noise_at) begin
                start     = 1'b1;
                src_addr  = 8'(s) ^ 8'h55;
                dst_addr  = 8'(d) ^ 8'h0F;
                row_count = 9'(n + 3);
            end
            if (ab >= 0 && rel == ab + 1) chk_int({tag, "_busy_after_abort"}, int'(busy), 0);
            if (rel >= 2 && !busy) finished = 1'b1;
        end
        start = 1'b0; abort = 1'b0;
        if (!finished) chk_int({tag, "_timeout"}, 1, 0);
        cmp_q({tag, "_rd"},   e_rd,   a_rd);
        cmp_q({tag, "_relu"}, e_relu, a_relu);
        cmp_q({tag, "_wr"},   e_wr,   a_wr);
        cmp_q({tag, "_wra"},  e_wra,  a_wra);
        cmp_q({tag, "_done"}, e_done, a_done);
    endtask

    function automatic int done_cyc();
        return (a_done.size() > 0) ? a_done[0] / 256 : -1;
    endfunction

    task automatic chk_outs_zero(input string tag);
        chk_int({tag, "_rd_en"},   int'(acc_rd_en),   0);
        chk_int({tag, "_rd_addr"}, int'(acc_rd_addr), 0);
        chk_int({tag, "_relu"},    int'(relu_en),     0);
        chk_int({tag, "_wr_en"},   int'(ub_wr_en),    0);
        chk_int({tag, "_wr_addr"}, int'(ub_wr_addr),  0);
        chk_int({tag, "_busy"},    int'(busy),        0);
        chk_int({tag, "_done"},    int'(done),        0);
    endtask

    initial begin
        #2;
        chk_outs_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: basic four-row block
        fill_pat(1'b0);
        run_cmd("t1", 'h10, 'h20, 4, -1, -1);
        chk_int("t1_done_cycle", done_cyc(), 13);

        // 2: empty block
        run_cmd("t2", 'h33, 'h44, 0, -1, -1);
        chk_int("t2_done_cycle", done_cyc(), 1);

        // 3: five stall cycles on row 0
        fill_pat(1'b0);
        for (int i = 3; i <= 7; i++) pat[i] = 1'b0;
        run_cmd("t3", 'h05, 'h40, 2, -1, -1);
        chk_int("t3_done_cycle", done_cyc(), 12);
        chk_int("t3_wr_en_cycles", a_wra.size(), 7);

        // 4: address wrap
        fill_pat(1'b0);
        run_cmd("t4", 'hFE, 'hFF, 3, -1, -1);

        // 5: abort in row 2 CAP, then a normal command
        run_cmd("t5", 'h00, 'h80, 8, 8, -1);
        chk_int("t5_writes", a_wr.size(), 2);
        fill_pat(1'b1);
        run_cmd("t5b", 'h21, 'h31, 5, -1, -1);

        // 6a: start while busy is ignored
        run_cmd("t6a", 'h60, 'h70, 5, -1, 5);

        // abort together with start in IDLE drops the start
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; row_count = 9'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk_int("idle_abort_busy", int'(busy), 0);
        chk_int("idle_abort_rd", int'(acc_rd_en), 0);

        // 6b: reset asserted during WR
        fill_pat(1'b0);
        @(posedge clk); #1;
        src_addr = 8'h90; dst_addr = 8'hA0; row_count = 9'd4; start = 1'b1; ub_wr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk_int("t6b_in_wr", int'(ub_wr_en), 1);
        #2 reset = 1'b0;
        #1 chk_outs_zero("t6b_async");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_outs_zero("t6b_release");

        // full 256-row block exercises the top count bit
        run_cmd("full", 'h00, 'h00, 256, -1, -1);

        // randomized commands with random backpressure
        for (int r = 0; r < 8; r++) begin
            fill_pat(1'b1);
            run_cmd("rnd", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 12)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
